// File: rtl/cordic_pkg.sv
// Shared widths, fixed-point constants and scheduler state encoding for the
// e^x CORDIC scheduler.
package cordic_pkg;

  localparam int X_W    = 32;
  localparam int Y_W    = 64;
  localparam int FRAC_X = 16;
  localparam int FRAC_Y = 32;

  localparam logic [Y_W-1:0] ONE_Y = 64'h0000_0001_0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    START,
    WAIT,
    RESP
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first asserted request at or after the
// pointer, wrapping past N_REQ-1 back to 0.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  logic [ID_W-1:0] candIdx;

  always_comb begin
    candIdx = '0;
    gnt_o   = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      candIdx = ID_W'((int'(ptr_i) + k) % N_REQ);
      if (!any_o && req_i[candIdx]) begin
        any_o          = 1'b1;
        gnt_o[candIdx] = 1'b1;
        idx_o          = candIdx;
      end
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Time-shares one e^x CORDIC engine among N_REQ requesters: round-robin grant,
// engine re-init/start sequencing, watchdog abort and a tagged response channel.
module cordic_sched
  import cordic_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 48
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*X_W-1:0]   req_x,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [ID_W-1:0]        resp_id,
  output logic [Y_W-1:0]         resp_y,
  output logic                   resp_err,
  output logic [X_W-1:0]         eng_x,
  output logic                   eng_rst,
  output logic                   eng_en,
  input  logic [Y_W-1:0]         eng_y,
  input  logic                   eng_valid
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  sched_state_t    state_q, state_d;
  logic [ID_W-1:0] rrPtr_q, rrPtr_d;
  logic [ID_W-1:0] opId_q, opId_d;
  logic [X_W-1:0]  opX_q, opX_d;
  logic [Y_W-1:0]  respY_q, respY_d;
  logic            respErr_q, respErr_d;
  logic [WD_W-1:0] wdog_q, wdog_d;

  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  gntIdx;
  logic             gntAny;
  logic [WD_W-1:0]  wdNext;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (rrPtr_q),
    .gnt_o (gnt),
    .idx_o (gntIdx),
    .any_o (gntAny)
  );

  assign wdNext = wdog_q + WD_W'(1);

  always_comb begin
    state_d    = state_q;
    rrPtr_d    = rrPtr_q;
    opId_d     = opId_q;
    opX_d      = opX_q;
    respY_d    = respY_q;
    respErr_d  = respErr_q;
    wdog_d     = wdog_q;
    req_ready  = '0;
    resp_valid = 1'b0;
    eng_rst    = rst;
    eng_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (gntAny && !rst) begin
          req_ready = gnt;
          opId_d    = gntIdx;
          opX_d     = req_x[int'(gntIdx)*X_W +: X_W];
          rrPtr_d   = ID_W'((int'(gntIdx) + 1) % N_REQ);
          state_d   = INIT;
        end
      end
      INIT: begin
        eng_rst = 1'b1;
        state_d = START;
      end
      START: begin
        eng_en  = !rst;
        wdog_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wdog_d = wdNext;
        // A result landing on the same cycle as the deadline still counts.
        if (eng_valid) begin
          respY_d   = eng_y;
          respErr_d = 1'b0;
          state_d   = RESP;
        end else if (wdNext == WD_W'(TIMEOUT)) begin
          respY_d   = '0;
          respErr_d = 1'b1;
          eng_rst   = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rrPtr_q   <= '0;
      opId_q    <= '0;
      opX_q     <= '0;
      respY_q   <= '0;
      respErr_q <= 1'b0;
      wdog_q    <= '0;
    end else begin
      state_q   <= state_d;
      rrPtr_q   <= rrPtr_d;
      opId_q    <= opId_d;
      opX_q     <= opX_d;
      respY_q   <= respY_d;
      respErr_q <= respErr_d;
      wdog_q    <= wdog_d;
    end
  end

  assign resp_id  = opId_q;
  assign resp_y   = respY_q;
  assign resp_err = respErr_q;
  assign eng_x    = opX_q;

endmodule

// File: tb/tb_cordic_sched.sv
// Bench for cordic_sched: behavioural engine stub, a scoreboard model of grant
// order and responses, and directed scenarios with hand-computed expectations.
module tb_cordic_sched;

  localparam int N  = 4;
  localparam int TO = 48;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   req_valid;
  logic [127:0] req_x;
  logic [3:0]   req_ready;
  logic         resp_valid;
  logic         resp_ready;
  logic [1:0]   resp_id;
  logic [63:0]  resp_y;
  logic         resp_err;
  logic [31:0]  eng_x;
  logic         eng_rst;
  logic         eng_en;
  logic [63:0]  eng_y;
  logic         eng_valid;

  int testsRun    = 0;
  int testsFailed = 0;
  int cycle       = 0;

  cordic_sched #(.N_REQ(N), .ID_W(2), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_x      (req_x),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_y     (resp_y),
    .resp_err   (resp_err),
    .eng_x      (eng_x),
    .eng_rst    (eng_rst),
    .eng_en     (eng_en),
    .eng_y      (eng_y),
    .eng_valid  (eng_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // e^x in 32.32 from a 16.16 operand, straight from real arithmetic.
  function automatic logic [63:0] modelY(input logic [31:0] x);
    real xr;
    xr = $itor($signed(x)) / 65536.0;
    return 64'(longint'($exp(xr) * 4294967296.0));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkNear(input string name, input logic [63:0] act, input logic [63:0] exp,
                           input longint tol);
    longint d;
    d = longint'(act) - longint'(exp);
    if (d < 0) d = -d;
    testsRun++;
    if (d > tol) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h +/- %0d", name, act, exp, tol);
    end
  endtask

  // Engine stub: eng_rst loads x and marks the engine fresh; eng_en without a
  // re-init in between just repeats the stale result.
  int          engLatency = 33;
  bit          engHang    = 1'b0;
  bit          spurValid  = 1'b0;
  bit          engFresh   = 1'b0;
  bit          engActive  = 1'b0;
  int          engCnt     = 0;
  logic [31:0] engXLoad   = '0;
  logic [63:0] engYReg    = '0;

  always @(posedge clk) begin
    if (eng_rst) begin
      engFresh  <= 1'b1;
      engXLoad  <= eng_x;
      engActive <= 1'b0;
    end else if (eng_en) begin
      if (engFresh) engYReg <= modelY(engXLoad);
      engFresh  <= 1'b0;
      engActive <= !engHang;
      engCnt    <= engLatency - 1;
    end else if (engActive) begin
      if (engCnt == 0) engActive <= 1'b0;
      else engCnt <= engCnt - 1;
    end
  end

  assign eng_y     = engYReg;
  assign eng_valid = (engActive && engCnt == 0) || spurValid;

  // Scoreboard: expected grant each cycle and expected response per accepted op.
  typedef struct {
    logic [1:0]  id;
    logic [31:0] x;
    bit          err;
  } op_t;

  op_t         sb[$];
  int          mPtr  = 0;
  bit          mBusy = 1'b0;
  int          respIds[$];
  logic [63:0] respYs[$];

  always @(negedge clk) begin
    logic [3:0] expReady;
    int         c;
    op_t        e;
    expReady = '0;
    c        = 0;
    if (rst) begin
      sb.delete();
      mPtr  = 0;
      mBusy = 1'b0;
    end else begin
      if (!mBusy) begin
        for (int k = 0; k < N; k++) begin
          c = (mPtr + k) % N;
          if (expReady == 4'b0 && req_valid[c]) expReady[c] = 1'b1;
        end
      end
      checkOutput("req_ready", 64'(req_ready), 64'(expReady));
      if (expReady != 4'b0 && (req_valid & req_ready) != 4'b0) begin
        for (int k = 0; k < N; k++) begin
          if (expReady[k]) begin
            e.id  = 2'(k);
            e.x   = req_x[k*32 +: 32];
            e.err = engHang;
            sb.push_back(e);
            mPtr  = (k + 1) % N;
            mBusy = 1'b1;
          end
        end
      end
      if (resp_valid && resp_ready) begin
        if (sb.size() == 0) begin
          checkOutput("resp_unexpected", 64'(resp_valid), 64'(0));
        end else begin
          e = sb.pop_front();
          checkOutput("resp_id", 64'(resp_id), 64'(e.id));
          checkOutput("resp_err", 64'(resp_err), 64'(e.err));
          if (e.err) checkOutput("resp_y_err", resp_y, 64'(0));
          else checkNear("resp_y", resp_y, modelY(e.x), 1);
          respIds.push_back(int'(resp_id));
          respYs.push_back(resp_y);
          mBusy = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] v, input logic [127:0] xs, input logic rdy);
    @(posedge clk);
    #1;
    req_valid  = v;
    req_x      = xs;
    resp_ready = rdy;
  endtask

  task automatic waitAccept(input string name);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((req_valid & req_ready) == 4'b0 && guard < 200);
    checkOutput(name, 64'(|(req_valid & req_ready)), 64'(1));
  endtask

  task automatic pulseReset();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    int tAcc, tRst, tEn, tResp, guard, rstCnt;
    bit sawResp;
    int expOrder[5];
    expOrder = '{0, 1, 2, 3, 0};

    rst        = 1'b1;
    req_valid  = '0;
    req_x      = '0;
    resp_ready = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_req_ready", 64'(req_ready), 64'(0));
    checkOutput("rst_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("rst_resp_id", 64'(resp_id), 64'(0));
    checkOutput("rst_resp_y", resp_y, 64'(0));
    checkOutput("rst_resp_err", 64'(resp_err), 64'(0));
    checkOutput("rst_eng_x", 64'(eng_x), 64'(0));
    checkOutput("rst_eng_rst", 64'(eng_rst), 64'(1));
    checkOutput("rst_eng_en", 64'(eng_en), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;

    // Single op, x = 1.0, nominal engine latency
    $display("[TB] single request latency");
    applyStimulus(4'b0001, {96'h0, 32'h0001_0000}, 1'b1);
    tAcc = -1; tRst = -1; tEn = -1; tResp = -1;
    for (int i = 0; i < 200 && tResp < 0; i++) begin
      @(negedge clk);
      if (tAcc < 0 && req_valid[0] && req_ready[0]) tAcc = cycle;
      else if (tAcc >= 0) begin
        if (eng_rst && tRst < 0) tRst = cycle;
        if (eng_en && tEn < 0) tEn = cycle;
        if (resp_valid && tResp < 0) begin
          tResp = cycle;
          checkNear("e_literal", resp_y, 64'h2_B7E1_5163, 1);
        end
      end
      if (tAcc >= 0 && req_valid[0]) applyStimulus(4'b0000, req_x, 1'b1);
    end
    checkOutput("lat_eng_rst", 64'(tRst), 64'(tAcc + 1));
    checkOutput("lat_eng_en", 64'(tEn), 64'(tAcc + 2));
    checkOutput("lat_resp", 64'(tResp), 64'(tAcc + 36));
    repeat (3) @(negedge clk);

    // Back-to-back from req1: x = 0, then x = 2.0 requires a fresh engine
    $display("[TB] back-to-back re-init");
    respYs.delete();
    applyStimulus(4'b0010, 128'h0, 1'b1);
    waitAccept("b2b_accept0");
    applyStimulus(4'b0010, {64'h0, 32'h0002_0000, 32'h0}, 1'b1);
    waitAccept("b2b_accept1");
    applyStimulus(4'b0000, req_x, 1'b1);
    guard = 0;
    while (respYs.size() < 2 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("b2b_count", 64'(respYs.size()), 64'(2));
    if (respYs.size() >= 2) begin
      checkOutput("b2b_e0", respYs[0], 64'h0000_0001_0000_0000);
      checkNear("b2b_e2", respYs[1], 64'h7_6399_2E35, 64);
    end

    // Round-robin with every requester asserting
    $display("[TB] round robin");
    pulseReset();
    engLatency = 5;
    respIds.delete();
    applyStimulus(4'b1111, {32'h0000_C000, 32'h0000_8000, 32'h0000_4000, 32'h0000_0000}, 1'b1);
    for (int n = 0; n < 5; n++) waitAccept("rr_accept");
    applyStimulus(4'b0000, req_x, 1'b1);
    guard = 0;
    while (respIds.size() < 5 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rr_count", 64'(respIds.size()), 64'(5));
    for (int n = 0; n < 5 && n < respIds.size(); n++)
      checkOutput("rr_order", 64'(respIds[n]), 64'(expOrder[n]));

    // Backpressure: result held, no further grant or engine start
    $display("[TB] backpressure");
    applyStimulus(4'b0100, {32'h0, 32'h0001_0000, 64'h0}, 1'b0);
    waitAccept("bp_accept");
    applyStimulus(4'b1000, req_x, 1'b0);
    guard = 0;
    while (!resp_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("bp_resp_seen", 64'(resp_valid), 64'(1));
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      checkOutput("bp_valid", 64'(resp_valid), 64'(1));
      checkNear("bp_y", resp_y, 64'h2_B7E1_5163, 1);
      checkOutput("bp_id", 64'(resp_id), 64'(2));
      checkOutput("bp_ready", 64'(req_ready), 64'(0));
      checkOutput("bp_en", 64'(eng_en), 64'(0));
    end
    applyStimulus(4'b0000, req_x, 1'b1);
    repeat (3) @(negedge clk);

    // Engine that never finishes
    $display("[TB] watchdog timeout");
    engHang = 1'b1;
    applyStimulus(4'b0001, {96'h0, 32'h0000_8000}, 1'b1);
    waitAccept("to_accept");
    applyStimulus(4'b0000, req_x, 1'b1);
    tEn = -1; tResp = -1; rstCnt = 0;
    for (int i = 0; i < 20 && tEn < 0; i++) begin
      @(negedge clk);
      if (eng_en) tEn = cycle;
    end
    for (int i = 0; i < 100 && tResp < 0; i++) begin
      @(negedge clk);
      if (eng_rst) rstCnt++;
      if (resp_valid) tResp = cycle;
    end
    checkOutput("to_resp_cycle", 64'(tResp), 64'(tEn + TO + 1));
    checkOutput("to_eng_rst_pulses", 64'(rstCnt), 64'(1));
    repeat (2) @(negedge clk);
    engHang = 1'b0;

    // Reset while waiting on the engine
    $display("[TB] reset mid-operation");
    engLatency = 33;
    applyStimulus(4'b1000, {32'h0001_0000, 96'h0}, 1'b1);
    waitAccept("mid_accept");
    applyStimulus(4'b0000, req_x, 1'b1);
    guard = 0;
    while (!eng_en && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("mid_eng_en_seen", 64'(eng_en), 64'(1));
    repeat (5) @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = 4'b0001;
    @(negedge clk);
    checkOutput("mid_resp_valid", 64'(resp_valid), 64'(0));
    checkOutput("mid_eng_rst", 64'(eng_rst), 64'(1));
    checkOutput("mid_req_ready", 64'(req_ready), 64'(0));
    checkOutput("mid_eng_en", 64'(eng_en), 64'(0));
    @(posedge clk);
    #1;
    rst       = 1'b0;
    req_valid = 4'b0000;
    @(posedge clk);
    #1 spurValid = 1'b1;
    @(posedge clk);
    #1 spurValid = 1'b0;
    sawResp = 1'b0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (resp_valid) sawResp = 1'b1;
    end
    checkOutput("mid_no_stale_resp", 64'(sawResp), 64'(0));

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete, got time %0t, expected < 200000", $time);
    $fatal(1, "[TB] global timeout");
  end

endmodule
